fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Front-end instruction fetch stage feeding the RV32 decoder.
- Holds the PC and issues word-aligned requests to the instruction cache.
- Applies branch-predictor redirects and buffers responses in an in-order queue.
- Presents instructions through the fetch→decode valid/stall interface and restarts on ROB flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset (bits [1:0] must be 0).
- QDEPTH, 4, total slots shared by in-flight requests and buffered instructions (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- fetch_ic_req  out  1  icache request valid
- fetch_ic_addr  out  30  request word address [31:2]
- ic_ready  in  1  icache accepts request this cycle
- ic_resp_valid  in  1  response valid; responses return in order
- ic_resp_error  in  1  access fault for response
- ic_resp_insn  in  32  response instruction word
- fetch_bp_pc  out  30  predictor lookup address (= current PC[31:2])
- bp_taken  in  1  predicted taken for fetch_bp_pc (combinational)
- bp_tag  in  16  predictor tag for fetch_bp_pc
- bp_target  in  31  predicted target [31:1]
- fetch_de_valid  out  1  instruction valid to decode
- fetch_de_error  out  1  fetch fault or misalignment
- fetch_de_addr  out  31  instruction address [31:1]
- fetch_de_insn  out  32  instruction word
- fetch_de_bptag  out  16  predictor tag
- fetch_de_bptaken  out  1  predicted taken
- decode_stall  in  1  decode not accepting
- rob_flush  in  1  redirect
- rob_flush_pc  in  31  redirect target [31:1]

Behaviour:
- Reset (rst=0, async): pc=RESET_PC[31:1]; state=RUN; all queues and counters empty.
- Reset output values: fetch_ic_req=0, fetch_de_valid=0, fetch_de_error=0, all other outputs 0 except fetch_ic_addr and fetch_bp_pc, which equal RESET_PC[31:2].
- Slot accounting: used = pending + outq_count + drop_cnt.
  - pending: requests issued, response not yet received; the pending queue holds {addr, bptag, bptaken}.
  - outq: output queue of {error, addr, insn, bptag, bptaken}.
- States:
  - RUN: fetch_ic_req = (used < QDEPTH) & ~rob_flush.
  - On handshake (req & ic_ready):
    - push {pc, bp_tag, bp_taken} to the pending queue.
    - pc ← bp_taken ? bp_target : pc+4 (word increment).
    - If the new pc has bit1 set → MISALIGN.
  - MISALIGN: no requests. When pending==0 and outq is not full, enqueue {error=1, addr=pc, insn=0, bptag=0, bptaken=0} → HALT.
  - HALT: no requests until rob_flush.
  - Response handling: if drop_cnt>0, discard the response and decrement drop_cnt. Otherwise pop the pending head and push {ic_resp_error, addr, ic_resp_insn, tag, taken} to outq.
  - A response with ic_resp_error=1 → HALT after enqueue; remaining pending responses are still enqueued.
- Decode handshake:
  - fetch_de_* driven from the outq head; fetch_de_valid = ~empty.
  - Head pops when valid & ~decode_stall (the decoder captures in the same cycle).
  - Push and pop in the same cycle are allowed.
- Flush (highest priority, one cycle):
  - outq cleared; pending queue cleared.
  - drop_cnt ← drop_cnt + pending − (ic_resp_valid ? 1 : 0), so a response arriving in the flush cycle is dropped.
  - pc ← rob_flush_pc.
  - State ← MISALIGN if rob_flush_pc[1], else RUN.
  - No request is issued in the flush cycle; the first request can go out the following cycle.
- Latency: request → fetch_de_valid is 1 cycle after ic_resp_valid (outq is registered).
- Overflow is impossible by the credit rule. An ic_resp_valid with pending==0 and drop_cnt==0 is a protocol error; assert in simulation.

Optional Feature:
- FETCH_BP_EN defined: predictor inputs are used as above.
- Undefined: bp_taken/bp_tag/bp_target are ignored, the next pc is always pc+4, and bptag=0, bptaken=0 are enqueued. The ports remain.

Decomposition:
- Package fetch_pkg: fetch-state encoding (RUN, MISALIGN, HALT) and the outq/pending entry field widths.
- Sub-module fetch_fifo (parameterised width/depth, push/pop/flush, count, full/empty) instantiated twice: pending queue and outq.

Test Plan:
- Reset, ic_ready=1, 1-cycle icache, decode_stall=0 → requests at 0x0, 0x4, 0x8…; fetch_de_addr 0x0, 0x4 in consecutive cycles carrying the returned words.
- decode_stall=1 held → at most QDEPTH=4 requests outstanding/buffered; release → four instructions delivered in order, none lost or duplicated.
- FETCH_BP_EN, bp_taken=1, bp_target=0x100 at pc 0x8 → next request 0x100; entry for 0x8 carries bptaken=1 and the given bp_tag.
- Flush to 0x200 with 2 requests pending → both late responses discarded; next fetch_de_addr=0x200.
- Flush to 0x202 → no icache request; single entry error=1, addr=0x202; then idle until the next flush.
- ic_resp_error=1 on 0x10 → entry error=1, addr=0x10; fetch_ic_req stays 0 until rob_flush.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM state encoding and queue entry layouts.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISALIGN = 2'd1,
    ST_HALT     = 2'd2
  } fetch_state_e;

  localparam int ADDR_W = 31;  // halfword address [31:1]
  localparam int INSN_W = 32;
  localparam int TAG_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic              taken;
  } pend_entry_t;

  typedef struct packed {
    logic              error;
    logic [ADDR_W-1:0] addr;
    logic [INSN_W-1:0] insn;
    logic [TAG_W-1:0]  tag;
    logic              taken;
  } out_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; used for the pending and output queues.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_en, pop_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_en  = pop_i & ~empty_o;
  // a full queue can still take a push when the head leaves in the same cycle
  assign push_en = push_i & (~full_o | pop_en);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + AW'(1);
      if (pop_en)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, icache requests, in-order response queue, decode interface.
// Branch prediction is used only when FETCH_BP_EN is defined.
//   state    | meaning
//   RUN      | issuing requests while queue slots are free
//   MISALIGN | pc has bit1 set; report it once pending responses drain
//   HALT     | no requests until rob_flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_ic_req,
  output logic [29:0] fetch_ic_addr,
  input  logic        ic_ready,
  input  logic        ic_resp_valid,
  input  logic        ic_resp_error,
  input  logic [31:0] ic_resp_insn,
  output logic [29:0] fetch_bp_pc,
  input  logic        bp_taken,
  input  logic [15:0] bp_tag,
  input  logic [30:0] bp_target,
  output logic        fetch_de_valid,
  output logic        fetch_de_error,
  output logic [30:0] fetch_de_addr,
  output logic [31:0] fetch_de_insn,
  output logic [15:0] fetch_de_bptag,
  output logic        fetch_de_bptaken,
  input  logic        decode_stall,
  input  logic        rob_flush,
  input  logic [30:0] rob_flush_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:1]  pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          pend_push, pend_pop, pend_empty, pend_full;
  logic [CW-1:0] pend_count;
  pend_entry_t   pend_din, pend_head;
  logic          outq_push, outq_pop, outq_empty, outq_full;
  logic [CW-1:0] outq_count;
  out_entry_t    outq_din, outq_head, de;

  logic          bp_taken_eff;
  logic [15:0]   bp_tag_eff;
  logic [30:0]   bp_target_eff;
  logic [CW:0]   used;
  logic          ic_req, resp_drop, resp_take;

`ifdef FETCH_BP_EN
  assign bp_taken_eff  = bp_taken;
  assign bp_tag_eff    = bp_tag;
  assign bp_target_eff = bp_target;
`else
  logic unused_bp;
  assign unused_bp     = ^{bp_taken, bp_tag, bp_target};
  assign bp_taken_eff  = 1'b0;
  assign bp_tag_eff    = '0;
  assign bp_target_eff = '0;
`endif

  assign used      = {1'b0, pend_count} + {1'b0, outq_count} + {1'b0, drop_q};
  assign resp_drop = ic_resp_valid & (drop_q != '0);
  assign resp_take = ic_resp_valid & (drop_q == '0) & ~pend_empty;
  assign outq_pop  = ~outq_empty & ~decode_stall;
  assign pend_din  = '{addr: pc_q, tag: bp_tag_eff, taken: bp_taken_eff};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    ic_req    = 1'b0;
    pend_push = 1'b0;
    pend_pop  = 1'b0;
    outq_push = 1'b0;
    outq_din  = '0;
    if (rob_flush) begin
      // a response landing in the flush cycle is consumed by the new drop count
      pc_d    = rob_flush_pc;
      drop_d  = drop_q + pend_count - CW'(ic_resp_valid);
      state_d = rob_flush_pc[0] ? ST_MISALIGN : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          ic_req = rst & (used < (CW+1)'(QDEPTH));
          if (ic_req && ic_ready) begin
            pend_push = 1'b1;
            pc_d      = bp_taken_eff ? bp_target_eff : pc_q + 31'd2;
            if (pc_d[1]) state_d = ST_MISALIGN;
          end
        end
        ST_MISALIGN: begin
          if (pend_empty && !outq_full) begin
            outq_push = 1'b1;
            outq_din  = '{error: 1'b1, addr: pc_q, insn: '0, tag: '0, taken: 1'b0};
            state_d   = ST_HALT;
          end
        end
        default: ;
      endcase
      if (resp_drop) drop_d = drop_q - CW'(1);
      if (resp_take) begin
        pend_pop  = 1'b1;
        outq_push = 1'b1;
        outq_din  = '{error: ic_resp_error, addr: pend_head.addr, insn: ic_resp_insn,
                      tag: pend_head.tag, taken: pend_head.taken};
        if (ic_resp_error) state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC[31:1];
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.W($bits(pend_entry_t)), .DEPTH(QDEPTH)) u_pend (
    .clk_i(clk), .rst_n_i(rst), .push_i(pend_push), .din_i(pend_din),
    .pop_i(pend_pop), .flush_i(rob_flush), .dout_o(pend_head),
    .count_o(pend_count), .full_o(pend_full), .empty_o(pend_empty)
  );

  fetch_fifo #(.W($bits(out_entry_t)), .DEPTH(QDEPTH)) u_outq (
    .clk_i(clk), .rst_n_i(rst), .push_i(outq_push), .din_i(outq_din),
    .pop_i(outq_pop), .flush_i(rob_flush), .dout_o(outq_head),
    .count_o(outq_count), .full_o(outq_full), .empty_o(outq_empty)
  );

  logic unused_full;
  assign unused_full = pend_full;

  assign de               = outq_empty ? '0 : outq_head;
  assign fetch_ic_req     = ic_req;
  assign fetch_ic_addr    = pc_q[31:2];
  assign fetch_bp_pc      = pc_q[31:2];
  assign fetch_de_valid   = ~outq_empty;
  assign fetch_de_error   = de.error;
  assign fetch_de_addr    = de.addr;
  assign fetch_de_insn    = de.insn;
  assign fetch_de_bptag   = de.tag;
  assign fetch_de_bptaken = de.taken;

  // responses must never arrive with nothing outstanding
  assert property (@(posedge clk) disable iff (!rst)
    !(ic_resp_valid && pend_empty && (drop_q == '0)));

endmodule
